// File: rtl/iwrite_controller_pp.sv
// Input-write controller: splits a layer frame into header, instructions
// and activations, striping activations over ping-pong IBRAM halves.
module iwrite_controller_pp #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int IBRAM_DEPTH  = 64,
  parameter int CNT_W        = 16,
  parameter int PARAM_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STREAM_WIDTH-1:0]        s_tdata,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [$clog2(IBRAM_DEPTH)-1:0] bram_addr,
  output logic [STREAM_WIDTH-1:0]        bram_din,
  output logic [NUM_BANKS-1:0]           bram_en,
  output logic [NUM_BANKS-1:0]           bram_we,
  output logic [STREAM_WIDTH-1:0]        instr_data,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [CNT_W-1:0]               instr_idx,
  output logic [PARAM_WIDTH-1:0]         param_data,
  output logic                           param_half,
  output logic                           param_valid,
  input  logic                           param_ready,
  input  logic [1:0]                     buf_release,
  output logic [1:0]                     buf_full,
  output logic                           err_overflow
);

  localparam int AW = $clog2(IBRAM_DEPTH);
  localparam int RW = AW - 1;
  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [31:0] CAP = 32'(NUM_BANKS * IBRAM_DEPTH / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_ACT, S_DROP, S_PUB
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       act_q, act_d;
  logic [CNT_W-1:0]       ins_q, ins_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PARAM_WIDTH-1:0] param_q, param_d;
  logic [BW-1:0]          bank_q, bank_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   half_q, half_d;
  logic [1:0]             full_q, full_d;
  logic                   err_q, err_d;
  logic [NUM_BANKS-1:0]   en_q;
  logic [AW-1:0]          addr_q;
  logic [STREAM_WIDTH-1:0] din_q;
  logic                   rdy, wr_go, pub;

  wire [CNT_W-1:0] h_act = s_tdata[CNT_W-1:0];
  wire [CNT_W-1:0] h_ins = s_tdata[2*CNT_W-1:CNT_W];
  wire [PARAM_WIDTH-1:0] h_par =
    s_tdata[2*CNT_W+PARAM_WIDTH-1:2*CNT_W];

  // Where a frame goes once its instruction words are done.
  function automatic state_t route(input logic [CNT_W-1:0] a);
    if (a == '0) return S_PUB;
    else if (32'(a) > CAP) return S_DROP;
    else return S_ACT;
  endfunction

  always_comb begin
    state_d = state_q;
    act_d = act_q;
    ins_d = ins_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    param_d = param_q;
    bank_d = bank_q;
    row_d = row_q;
    half_d = half_q;
    err_d = err_q;
    rdy = 1'b0;
    wr_go = 1'b0;
    pub = 1'b0;
    instr_valid = 1'b0;
    param_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rdy = !full_q[half_q];
        if (s_tvalid && rdy) begin
          act_d = h_act;
          ins_d = h_ins;
          param_d = h_par;
          idx_d = '0;
          cnt_d = '0;
          bank_d = '0;
          row_d = '0;
          state_d = (h_ins != '0) ? S_INSTR : route(h_act);
        end
      end
      S_INSTR: begin
        rdy = instr_ready;
        instr_valid = s_tvalid;
        if (s_tvalid && instr_ready) begin
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == ins_q - CNT_W'(1))
            state_d = route(act_q);
        end
      end
      S_ACT: begin
        rdy = 1'b1;
        if (s_tvalid) begin
          wr_go = 1'b1;
          bank_d = bank_q + BW'(1);
          if (bank_q == BW'(NUM_BANKS - 1))
            row_d = row_q + RW'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == act_q - CNT_W'(1))
            state_d = S_PUB;
        end
      end
      S_DROP: begin
        rdy = 1'b1;
        if (s_tvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == act_q - CNT_W'(1))
            state_d = S_IDLE;
        end
      end
      S_PUB: begin
        param_valid = 1'b1;
        if (param_ready) begin
          pub = 1'b1;
          half_d = ~half_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DROP) err_d = 1'b1;
    // Release first, then publish: both land when they hit different halves.
    full_d = full_q & ~buf_release;
    if (pub) full_d[half_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      act_q <= '0;
      ins_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      param_q <= '0;
      bank_q <= '0;
      row_q <= '0;
      half_q <= 1'b0;
      full_q <= '0;
      err_q <= 1'b0;
      en_q <= '0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      ins_q <= ins_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      param_q <= param_d;
      bank_q <= bank_d;
      row_q <= row_d;
      half_q <= half_d;
      full_q <= full_d;
      err_q <= err_d;
      if (wr_go) begin
        en_q <= NUM_BANKS'(1) << bank_q;
        addr_q <= {half_q, row_q};
        din_q <= s_tdata;
      end else begin
        en_q <= '0;
      end
    end
  end

  assign s_tready = rdy && !rst;
  assign bram_en = en_q;
  assign bram_we = en_q;
  assign bram_addr = addr_q;
  assign bram_din = din_q;
  assign instr_data = s_tdata;
  assign instr_idx = idx_q;
  assign param_data = param_q;
  assign param_half = half_q;
  assign buf_full = full_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_iwrite_controller_pp.sv
// Directed bench for iwrite_controller_pp: striping, instruction pass-through,
// ping-pong occupancy, overflow drop, empty frame and mid-frame reset.
module tb_iwrite_controller_pp;
  localparam int SW = 128;
  localparam int NB = 16;
  localparam int CW = 16;
  localparam int PW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  logic [SW-1:0] s_tdata;
  logic s_tvalid, s_tready;
  logic [AW-1:0] bram_addr;
  logic [SW-1:0] bram_din;
  logic [NB-1:0] bram_en, bram_we;
  logic [SW-1:0] instr_data;
  logic instr_valid, instr_ready;
  logic [CW-1:0] instr_idx;
  logic [PW-1:0] param_data;
  logic param_half, param_valid, param_ready;
  logic [1:0] buf_release, buf_full;
  logic err_overflow;

  int total = 0;
  int bad = 0;
  int n_instr = 0;
  int n_param = 0;
  int snap;
  logic [NB-1:0] q_we[$];
  logic [NB-1:0] q_en[$];
  logic [AW-1:0] q_addr[$];
  logic [SW-1:0] q_din[$];

  iwrite_controller_pp dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_en(bram_en), .bram_we(bram_we),
    .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_idx(instr_idx),
    .param_data(param_data), .param_half(param_half),
    .param_valid(param_valid), .param_ready(param_ready),
    .buf_release(buf_release), .buf_full(buf_full),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_we != '0 || bram_en != '0) begin
      q_we.push_back(bram_we);
      q_en.push_back(bram_en);
      q_addr.push_back(bram_addr);
      q_din.push_back(bram_din);
    end
    if (instr_valid && instr_ready) n_instr++;
    if (param_valid && param_ready) n_param++;
  end

  task automatic chk(input string tag, input logic [SW-1:0] obs,
                     input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] hdr(input int a, input int i,
                                        input logic [31:0] p);
    logic [SW-1:0] h;
    h = '0;
    h[15:0] = a[15:0];
    h[31:16] = i[15:0];
    h[63:32] = p;
    return h;
  endfunction

  function automatic logic [SW-1:0] aw(input int tag, input int k);
    return {64'(tag), 64'(k)};
  endfunction

  task automatic send(input logic [SW-1:0] d);
    int n;
    s_tdata = d;
    s_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_tready && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk("send_timeout", SW'(s_tready), 1);
    tick;
    s_tvalid = 1'b0;
  endtask

  task automatic publish(input logic h, input logic [31:0] p);
    chk("pub_valid", SW'(param_valid), 1);
    chk("pub_half", SW'(param_half), SW'(h));
    chk("pub_data", SW'(param_data), SW'(p));
    param_ready = 1'b1;
    tick;
    param_ready = 1'b0;
    chk("pub_done", SW'(param_valid), 0);
  endtask

  task automatic clear_log;
    q_we.delete();
    q_en.delete();
    q_addr.delete();
    q_din.delete();
  endtask

  task automatic check_log(input int n, input logic h, input int tag);
    int m;
    logic [AW-1:0] ea;
    logic [NB-1:0] ew;
    chk("log_count", SW'(q_we.size()), SW'(n));
    m = (q_we.size() < n) ? q_we.size() : n;
    for (int k = 0; k < m; k++) begin
      ea = {h, 5'(k / 16)};
      ew = NB'(1) << (k % 16);
      chk($sformatf("we[%0d]", k), SW'(q_we[k]), SW'(ew));
      chk($sformatf("en[%0d]", k), SW'(q_en[k]), SW'(ew));
      chk($sformatf("addr[%0d]", k), SW'(q_addr[k]), SW'(ea));
      chk($sformatf("din[%0d]", k), q_din[k], aw(tag, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_tdata = '0;
    s_tvalid = 1'b0;
    instr_ready = 1'b0;
    param_ready = 1'b0;
    buf_release = 2'b00;
    tick;
    tick;
    chk("rst_tready", SW'(s_tready), 0);
    chk("rst_we", SW'(bram_we), 0);
    chk("rst_full", SW'(buf_full), 0);
    chk("rst_err", SW'(err_overflow), 0);
    chk("rst_pvalid", SW'(param_valid), 0);
    rst = 1'b0;
    #1;
    chk("idle_tready", SW'(s_tready), 1);

    // Frame 1: 40 activations into half 0
    clear_log();
    send(hdr(40, 0, 32'hA5A5));
    for (int k = 0; k < 40; k++) send(aw(1, k));
    publish(1'b0, 32'hA5A5);
    chk("f1_full", SW'(buf_full), 2'b01);
    check_log(40, 1'b0, 1);

    // Frame 2: 3 instructions with instr_ready 1,0,1 then 2 activations
    clear_log();
    n_instr = 0;
    send(hdr(2, 3, 32'h1234));
    s_tvalid = 1'b1;
    s_tdata = aw(9, 0);
    instr_ready = 1'b1;
    #1;
    chk("i0_tready", SW'(s_tready), 1);
    chk("i0_valid", SW'(instr_valid), 1);
    chk("i0_idx", SW'(instr_idx), 0);
    chk("i0_data", instr_data, aw(9, 0));
    tick;
    s_tdata = aw(9, 1);
    instr_ready = 1'b0;
    #1;
    chk("i1_stall_tready", SW'(s_tready), 0);
    chk("i1_stall_idx", SW'(instr_idx), 1);
    tick;
    instr_ready = 1'b1;
    #1;
    chk("i1_tready", SW'(s_tready), 1);
    chk("i1_idx", SW'(instr_idx), 1);
    chk("i1_data", instr_data, aw(9, 1));
    tick;
    s_tdata = aw(9, 2);
    #1;
    chk("i2_idx", SW'(instr_idx), 2);
    chk("i2_data", instr_data, aw(9, 2));
    tick;
    s_tvalid = 1'b0;
    instr_ready = 1'b0;
    chk("instr_count", SW'(n_instr), 3);
    send(aw(2, 0));
    send(aw(2, 1));
    publish(1'b1, 32'h1234);
    chk("f2_full", SW'(buf_full), 2'b11);
    check_log(2, 1'b1, 2);

    // Frame 3: stalled header until half 0 is released
    clear_log();
    s_tdata = hdr(1, 0, 32'h77);
    s_tvalid = 1'b1;
    #1;
    chk("stall_a", SW'(s_tready), 0);
    tick;
    tick;
    chk("stall_b", SW'(s_tready), 0);
    buf_release = 2'b01;
    tick;
    buf_release = 2'b00;
    chk("unstall_tready", SW'(s_tready), 1);
    chk("unstall_full", SW'(buf_full), 2'b10);
    tick;
    s_tvalid = 1'b0;
    send(aw(3, 0));
    chk("f3_pvalid", SW'(param_valid), 1);
    chk("f3_phalf", SW'(param_half), 0);
    chk("f3_pdata", SW'(param_data), 32'h77);
    param_ready = 1'b1;
    buf_release = 2'b10;
    tick;
    param_ready = 1'b0;
    buf_release = 2'b00;
    chk("pub_and_rel", SW'(buf_full), 2'b01);
    check_log(1, 1'b0, 3);
    buf_release = 2'b10;
    tick;
    buf_release = 2'b00;
    chk("rel_not_full", SW'(buf_full), 2'b01);
    buf_release = 2'b01;
    tick;
    buf_release = 2'b00;
    chk("rel_half0", SW'(buf_full), 2'b00);

    // Frame 4: overflow (513 > 512) is dropped; half 1 stays next
    clear_log();
    snap = n_param;
    chk("err_pre", SW'(err_overflow), 0);
    send(hdr(513, 0, 32'hDEAD));
    for (int k = 0; k < 513; k++) send(aw(4, k));
    chk("drop_err", SW'(err_overflow), 1);
    chk("drop_pvalid", SW'(param_valid), 0);
    chk("drop_full", SW'(buf_full), 2'b00);
    chk("drop_idle", SW'(s_tready), 1);
    chk("drop_writes", SW'(q_we.size()), 0);
    chk("drop_pub", SW'(n_param), SW'(snap));
    send(hdr(3, 0, 32'hBEEF));
    for (int k = 0; k < 3; k++) send(aw(5, k));
    publish(1'b1, 32'hBEEF);
    check_log(3, 1'b1, 5);
    chk("f5_full", SW'(buf_full), 2'b10);
    chk("err_sticky", SW'(err_overflow), 1);

    // Frame 6: empty frame publishes straight away
    clear_log();
    send(hdr(0, 0, 32'h55));
    publish(1'b0, 32'h55);
    chk("empty_writes", SW'(q_we.size()), 0);
    chk("empty_full", SW'(buf_full), 2'b11);
    buf_release = 2'b11;
    tick;
    buf_release = 2'b00;
    chk("rel_both", SW'(buf_full), 2'b00);

    // Frame 7: reset in the middle of activations
    send(hdr(10, 0, 32'h66));
    for (int k = 0; k < 5; k++) send(aw(6, k));
    chk("pre_rst_we", SW'(bram_we), 16'h0010);
    s_tvalid = 1'b1;
    s_tdata = aw(6, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_tready", SW'(s_tready), 0);
    chk("mrst_we", SW'(bram_we), 0);
    chk("mrst_en", SW'(bram_en), 0);
    chk("mrst_addr", SW'(bram_addr), 0);
    chk("mrst_din", bram_din, 0);
    chk("mrst_err", SW'(err_overflow), 0);
    chk("mrst_full", SW'(buf_full), 0);
    chk("mrst_ivalid", SW'(instr_valid), 0);
    chk("mrst_idx", SW'(instr_idx), 0);
    chk("mrst_pvalid", SW'(param_valid), 0);
    tick;
    tick;
    s_tvalid = 1'b0;
    rst = 1'b0;
    clear_log();
    #1;
    chk("post_rst_tready", SW'(s_tready), 1);
    send(hdr(2, 0, 32'h99));
    send(aw(7, 0));
    send(aw(7, 1));
    publish(1'b0, 32'h99);
    check_log(2, 1'b0, 7);
    chk("post_rst_full", SW'(buf_full), 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iwrite_controller_pp.md
Name: iwrite_controller_pp

Overview:
- Parametrised successor input-write controller: consumes one AXI-Stream frame per layer. Frame = header word, then instruction words, then activation words.
- Forwards the layer parameter to the read controller and passes instructions to the instruction buffer.
- Stripes activations round-robin across NUM_BANKS IBRAM banks.
- Ping-pong double buffers the activation space: two halves of each bank's address range, each with its own occupancy flag, freed by the read side.

Parameters:
- STREAM_WIDTH, 128, stream/BRAM data width
- NUM_BANKS, 16, IBRAM bank count (power of 2, >=2)
- IBRAM_DEPTH, 64, rows per bank (power of 2); each ping-pong half holds IBRAM_DEPTH/2 rows
- CNT_W, 16, width of each header count field
- PARAM_WIDTH, 32, layer-parameter width; 2*CNT_W+PARAM_WIDTH <= STREAM_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_tdata  in  STREAM_WIDTH  stream data
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- bram_addr  out  $clog2(IBRAM_DEPTH)  {half, row}
- bram_din  out  STREAM_WIDTH  write data
- bram_en  out  NUM_BANKS  one-hot enable
- bram_we  out  NUM_BANKS  one-hot write enable
- instr_data  out  STREAM_WIDTH  instruction word
- instr_valid  out  1  instruction valid
- instr_ready  in  1  instruction buffer ready
- instr_idx  out  CNT_W  index of the current instruction word
- param_data  out  PARAM_WIDTH  layer parameter for the read controller
- param_half  out  1  buffer half holding this layer
- param_valid  out  1  parameter valid
- param_ready  in  1  read controller accepts
- buf_release  in  2  per-half one-cycle pulse: reader done with that half
- buf_full  out  2  half-occupied flags
- err_overflow  out  1  sticky: frame's activation count exceeded half capacity

Behaviour:
- Handshake: a beat transfers when s_tvalid && s_tready. Same rule for instr and param channels. Valid, once raised, holds with stable data until accepted.
- Header fields:
  - act_cnt = s_tdata[CNT_W-1:0]
  - ins_cnt = s_tdata[2*CNT_W-1:CNT_W]
  - param = s_tdata[2*CNT_W+PARAM_WIDTH-1:2*CNT_W]
- Half capacity CAP = NUM_BANKS*IBRAM_DEPTH/2 words.
- States: IDLE, INSTR, ACT, DROP, PUBLISH.
- IDLE:
  - s_tready = !buf_full[wr_half].
  - On header accept: latch counts and param; clear bank/row counters.
  - Next state: INSTR if ins_cnt>0; else ACT if 0<act_cnt<=CAP; else DROP if act_cnt>CAP; else PUBLISH.
- INSTR:
  - Combinational pass-through: instr_data=s_tdata, instr_valid=s_tvalid, s_tready=instr_ready.
  - instr_idx counts accepted words from 0.
  - After ins_cnt words, go to ACT, DROP or PUBLISH using the same act_cnt rule as IDLE.
- ACT:
  - s_tready=1. Each accepted beat registers one BRAM write (latency 1 cycle): bram_en=bram_we=one-hot(bank), bram_addr={wr_half,row}, bram_din=beat.
  - bank increments per beat; on wrap NUM_BANKS-1 -> 0, row increments.
  - Non-beat cycles: en/we = 0.
  - After act_cnt beats, go to PUBLISH.
- DROP:
  - s_tready=1; consumes act_cnt beats with no BRAM writes.
  - Sets err_overflow (sticky until rst).
  - Then go to IDLE; wr_half and buf_full are unchanged and param is not published.
- PUBLISH:
  - param_valid=1, param_half=wr_half.
  - On param_ready: set buf_full[wr_half], toggle wr_half, go to IDLE.
  - The last BRAM write has already issued before param_valid rises.
- Release:
  - buf_release[h] clears buf_full[h].
  - A release in the same cycle as the PUBLISH set of the other half: both take effect.
  - A release of a half that is not full is ignored.
- Backpressure: IDLE with both halves full holds s_tready=0 until a release arrives.
- Reset, including mid-frame: all state returns to IDLE. Every output is 0 (s_tready, instr_valid, param_valid, bram_en/we, bram_addr, bram_din, instr_idx, buf_full, err_overflow). wr_half=0. A partially written frame is discarded.

Test Plan:
- Header act=40, ins=0, param=0xA5A5, then 40 beats: writes banks 0..15 rows 0,1 and banks 0..7 row 2, addr MSB=0. param_valid with data 0xA5A5, half 0. buf_full=2'b01.
- Header ins=3, act=2 with instr_ready toggling 1,0,1: exactly 3 instr transfers with instr_idx 0,1,2, data matching; s_tready tracks instr_ready. Then 2 BRAM writes.
- Two frames with no release: the second frame writes with addr MSB=1 and buf_full=2'b11. Third header is stalled (s_tready=0) until buf_release=2'b01, then lands in half 0.
- act_cnt=CAP+1=513: 513 beats consumed, no bram_we, err_overflow=1, no param_valid, buf_full unchanged. The next valid frame proceeds normally.
- act=0, ins=0 header: goes directly to PUBLISH; param_valid=1, half marked full, no BRAM writes.
- rst asserted mid-ACT after 5 beats: outputs zero asynchronously. The post-reset frame starts at bank 0, row 0, half 0.
